// File: rtl/im_fetch_pkg.sv
// Shared constants and FSM encoding for the instruction-memory fetch controller,
// also used by the IM wrapper and the CPU top.
package im_fetch_pkg;
  localparam int IM_ADDR_W = 10;
  localparam int IM_DATA_W = 32;
  localparam int IM_DEPTH  = 1 << IM_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/im_fetch_skid.sv
// Instruction output register plus a one-entry skid buffer that catches the
// response of a read still in flight when the pipeline stalls.
module im_fetch_skid
  import im_fetch_pkg::*;
#(
  parameter int DATA_W = IM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              stall,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              skid_full
);
  logic [DATA_W-1:0] skid_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      skid_full   <= 1'b0;
      skid_data   <= '0;
    end else if (clear) begin
      // Flush/drain: everything buffered or arriving this cycle is dropped.
      instr_valid <= 1'b0;
      skid_full   <= 1'b0;
    end else if (stall) begin
      if (rsp_valid) begin
        skid_data <= rsp_data;
        skid_full <= 1'b1;
      end
    end else if (skid_full) begin
      instr       <= skid_data;
      instr_valid <= 1'b1;
      skid_full   <= rsp_valid;
      skid_data   <= rsp_data;
    end else if (rsp_valid) begin
      instr       <= rsp_data;
      instr_valid <= 1'b1;
    end else begin
      instr_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction-memory sequencer: shares the single-port IM between the program
// loader and the fetch stage, and holds the core in reset during a load.
module im_fetch_ctrl
  import im_fetch_pkg::*;
#(
  parameter int ADDR_W    = IM_ADDR_W,
  parameter int DATA_W    = IM_DATA_W,
  parameter bit BOOT_LOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              ld_start,
  input  logic [31:0]       pc,
  input  logic              fetch_req,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              core_run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  fetch_state_t      state;
  logic [ADDR_W-1:0] ld_addr;
  logic              inflight;
  logic              skid_full;
  logic              accept;
  logic              last_word;
  logic              clear;
  logic              unused_pc_hi;

  assign unused_pc_hi = ^pc[31:ADDR_W];

  assign accept    = (state == ST_LOAD) && ld_valid;
  assign last_word = ld_last || (ld_addr == {ADDR_W{1'b1}});
  assign ld_ready  = (state == ST_LOAD);
  assign mem_we    = accept;
  assign mem_wdata = accept ? ld_data : '0;

  // A reload request wins over flush; a flush frees the skid slot so it may read.
  assign mem_re = (state == ST_RUN) && !ld_start && fetch_req &&
                  (flush || (!stall && !skid_full));

  always_comb begin
    mem_addr = '0;
    if (accept)      mem_addr = ld_addr;
    else if (mem_re) mem_addr = pc[ADDR_W-1:0];
  end

  assign clear = flush || ld_start || (state != ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ld_addr  <= '0;
      inflight <= 1'b0;
      core_run <= 1'b0;
    end else begin
      inflight <= mem_re;
      case (state)
        ST_IDLE: begin
          state    <= BOOT_LOAD ? ST_LOAD : ST_RUN;
          core_run <= !BOOT_LOAD;
        end
        ST_LOAD: begin
          if (accept) begin
            // The address counter saturates: the top word always ends the load.
            if (ld_addr != {ADDR_W{1'b1}}) ld_addr <= ld_addr + 1'b1;
            if (last_word) begin
              state    <= ST_RUN;
              core_run <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (ld_start) begin
            state    <= ST_DRAIN;
            core_run <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!inflight) begin
            ld_addr <= '0;
            state   <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  im_fetch_skid #(.DATA_W(DATA_W)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .stall       (stall),
    .rsp_valid   (inflight),
    .rsp_data    (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .skid_full   (skid_full)
  );
endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl with a behavioural synchronous IM attached.
module tb_im_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, ld_ready, ld_last, ld_start;
  logic [31:0] ld_data, pc, instr, mem_wdata, mem_rdata;
  logic        fetch_req, stall, flush, instr_valid, core_run;
  logic [9:0]  mem_addr;
  logic        mem_re, mem_we;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] prog [3];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  im_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .ld_start(ld_start), .pc(pc), .fetch_req(fetch_req), .stall(stall), .flush(flush),
    .instr(instr), .instr_valid(instr_valid), .core_run(core_run),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (ld_ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ready: ld_ready=%b after %0d cycles, required 1", ld_ready, budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if ({ld_ready, instr_valid, core_run, mem_re, mem_we} !== 5'b0 ||
        instr !== 32'h0 || mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: rdy=%b iv=%b run=%b re=%b we=%b instr=%h addr=%h wdata=%h, required all 0",
               tag, ld_ready, instr_valid, core_run, mem_re, mem_we, instr, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; ld_valid = 0; ld_data = 0; ld_last = 0; ld_start = 0;
    pc = 0; fetch_req = 0; stall = 0; flush = 0;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset_state");
    tick();
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_load();
    wait_ready(5);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_data = prog[i]; ld_last = (i == 2);
      #1;
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 10'(i) || mem_wdata !== prog[i] || core_run !== 1'b0) begin
        n_fail++;
        $display("FAIL load_write%0d: we=%b addr=%h wdata=%h run=%b, required 1/%h/%h/0",
                 i, mem_we, mem_addr, mem_wdata, core_run, 10'(i), prog[i]);
      end
      $display("load word %0d addr=%h data=%h", i, mem_addr, mem_wdata);
      tick();
    end
    ld_valid = 0; ld_last = 0;
    #1;
    n_checks++;
    if (core_run !== 1'b1 || ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_to_run: run=%b rdy=%b, required 1/0", core_run, ld_ready);
    end
  endtask

  task automatic test_back_to_back();
    fetch_req = 1; pc = 0; #1;
    n_checks++;
    if (mem_re !== 1'b1 || mem_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL b2b_issue: re=%b addr=%h, required 1/000", mem_re, mem_addr);
    end
    tick(); pc = 1; tick(); pc = 2; #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) fetch_req = 0;
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== prog[i]) begin
        n_fail++;
        $display("FAIL b2b_instr%0d: valid=%b instr=%h, required 1/%h", i, instr_valid, instr, prog[i]);
      end
      $display("fetch %0d instr=%h valid=%b", i, instr, instr_valid);
      tick();
    end
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: valid=%b, required 0", instr_valid);
    end
  endtask

  task automatic test_stall();
    fetch_req = 1; pc = 0; tick(); pc = 1; tick();
    stall = 1; pc = 2;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (mem_re !== 1'b0 || instr_valid !== 1'b1 || instr !== prog[0]) begin
        n_fail++;
        $display("FAIL stall_hold%0d: re=%b valid=%b instr=%h, required 0/1/%h",
                 k, mem_re, instr_valid, instr, prog[0]);
      end
      tick();
    end
    stall = 0; #1;
    n_checks++;
    if (mem_re !== 1'b0 || instr !== prog[0] || instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: re=%b valid=%b instr=%h, required 0/1/%h",
               mem_re, instr_valid, instr, prog[0]);
    end
    tick(); #1;
    n_checks++;
    if (mem_re !== 1'b1 || instr_valid !== 1'b1 || instr !== prog[1]) begin
      n_fail++;
      $display("FAIL stall_skid_out: re=%b valid=%b instr=%h, required 1/1/%h",
               mem_re, instr_valid, instr, prog[1]);
    end
    $display("stall released instr=%h", instr);
    tick(); fetch_req = 0; #1;
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_no_dup: valid=%b instr=%h, required valid 0", instr_valid, instr);
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== prog[2]) begin
      n_fail++;
      $display("FAIL stall_next: valid=%b instr=%h, required 1/%h", instr_valid, instr, prog[2]);
    end
    tick();
  endtask

  task automatic test_flush();
    fetch_req = 1; pc = 0; tick(); pc = 1; tick();
    stall = 1; flush = 1; pc = 2; #1;
    n_checks++;
    if (mem_re !== 1'b1 || mem_addr !== 10'd2) begin
      n_fail++;
      $display("FAIL flush_issue: re=%b addr=%h, required 1/002", mem_re, mem_addr);
    end
    tick(); stall = 0; flush = 0; fetch_req = 0; #1;
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_bubble: valid=%b instr=%h, required valid 0", instr_valid, instr);
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== prog[2]) begin
      n_fail++;
      $display("FAIL flush_target: valid=%b instr=%h, required 1/%h", instr_valid, instr, prog[2]);
    end
    $display("flush target instr=%h", instr);
    tick();
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drop: valid=%b instr=%h, required valid 0", instr_valid, instr);
    end
  endtask

  task automatic test_full_load();
    int bad = 0;
    fetch_req = 1; pc = 0; flush = 1; ld_start = 1; #1;
    n_checks++;
    if (mem_re !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_priority: re=%b, required 0", mem_re);
    end
    tick(); fetch_req = 0; flush = 0; ld_start = 0; #1;
    n_checks++;
    if (core_run !== 1'b0 || instr_valid !== 1'b0 || ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: run=%b valid=%b rdy=%b, required 0/0/0", core_run, instr_valid, ld_ready);
    end
    tick();
    wait_ready(2);
    for (int i = 0; i < 1024; i++) begin
      ld_valid = 1; ld_data = 32'hA500_0000 | i; ld_last = 0; #1;
      if (mem_we !== 1'b1 || mem_addr !== 10'(i) || mem_wdata !== (32'hA500_0000 | i)) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL full_load_writes: %0d bad writes, required 0", bad);
    end
    $display("full load streamed 1024 words");
    ld_data = 32'hDEAD_BEEF; #1;
    n_checks++;
    if (ld_ready !== 1'b0 || mem_we !== 1'b0 || core_run !== 1'b1) begin
      n_fail++;
      $display("FAIL full_load_end: rdy=%b we=%b run=%b, required 0/0/1", ld_ready, mem_we, core_run);
    end
    tick(); ld_valid = 0;
    fetch_req = 1; pc = 1023; tick(); pc = 0; tick(); fetch_req = 0; #1;
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== 32'hA500_03FF) begin
      n_fail++;
      $display("FAIL full_load_top: valid=%b instr=%h, required 1/a50003ff", instr_valid, instr);
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== 32'hA500_0000) begin
      n_fail++;
      $display("FAIL full_load_base: valid=%b instr=%h, required 1/a5000000", instr_valid, instr);
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    ld_start = 1; tick(); ld_start = 0; tick();
    wait_ready(2);
    ld_valid = 1; ld_data = 32'h11; ld_start = 1; tick();
    ld_start = 0; ld_data = 32'h22; #1;
    n_checks++;
    if (ld_ready !== 1'b1 || mem_addr !== 10'd1) begin
      n_fail++;
      $display("FAIL ld_start_in_load: rdy=%b addr=%h, required 1/001", ld_ready, mem_addr);
    end
    tick(); ld_data = 32'h33; #1;
    rst_n = 1'b0; #1;
    check_reset_outputs("reset_mid_load");
    tick(); tick();
    rst_n = 1'b1; ld_valid = 0;
    wait_ready(5);
    ld_valid = 1; ld_data = 32'h44; ld_last = 1; #1;
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 32'h44) begin
      n_fail++;
      $display("FAIL reload_restart: we=%b addr=%h wdata=%h, required 1/000/00000044",
               mem_we, mem_addr, mem_wdata);
    end
    $display("reload after reset addr=%h data=%h", mem_addr, mem_wdata);
    tick(); ld_valid = 0; ld_last = 0; #1;
    n_checks++;
    if (core_run !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_run: run=%b, required 1", core_run);
    end
  endtask

  initial begin
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_8113;
    mem_rdata = 32'h0;
    test_reset();
    test_load();
    test_back_to_back();
    test_stall();
    test_flush();
    test_full_load();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
